// File: rtl/vga_frame_ctrl_if.sv
// Avalon-MM register bus between the HPS fabric and vga_frame_ctrl.
interface vga_frame_ctrl_if;
  logic        chipselect;
  logic        write;
  logic        read;
  logic [2:0]  address;
  logic [15:0] writedata;
  logic [15:0] readdata;

  modport master (
    output chipselect, write, read, address, writedata,
    input  readdata
  );

  modport slave (
    input  chipselect, write, read, address, writedata,
    output readdata
  );
endinterface

// File: rtl/vga_frame_ctrl.sv
// VGA raster timing plus shadowed game-object registers committed at vblank entry.
module vga_frame_ctrl #(
  parameter int unsigned H_TOTAL    = 1600,
  parameter int unsigned V_TOTAL    = 525,
  parameter int unsigned H_ACTIVE   = 1280,
  parameter int unsigned H_SYNC_BEG = 1312,
  parameter int unsigned H_SYNC_END = 1503,
  parameter int unsigned V_ACTIVE   = 480,
  parameter int unsigned V_SYNC_BEG = 490,
  parameter int unsigned V_SYNC_END = 491
) (
  input  logic              clk,
  input  logic              reset_n,
  vga_frame_ctrl_if.slave   bus,
  output logic              irq,
  output logic [10:0]       hcount,
  output logic [9:0]        vcount,
  output logic [9:0]        bird_y,
  output logic [10:0]       pipe0_x,
  output logic [9:0]        pipe0_gap,
  output logic [10:0]       pipe1_x,
  output logic [9:0]        pipe1_gap,
  output logic              VGA_CLK,
  output logic              VGA_HS,
  output logic              VGA_VS,
  output logic              VGA_BLANK_n,
  output logic              VGA_SYNC_n
);

  localparam int unsigned HW = 11;
  localparam int unsigned VW = 10;

  localparam logic [HW-1:0] H_LAST   = HW'(H_TOTAL - 1);
  localparam logic [VW-1:0] V_LAST   = VW'(V_TOTAL - 1);
  localparam logic [HW-1:0] H_ACT    = HW'(H_ACTIVE);
  localparam logic [HW-1:0] HS_BEG   = HW'(H_SYNC_BEG);
  localparam logic [HW-1:0] HS_END   = HW'(H_SYNC_END);
  localparam logic [VW-1:0] V_ACT    = VW'(V_ACTIVE);
  localparam logic [VW-1:0] V_COMMIT = VW'(V_ACTIVE - 1);
  localparam logic [VW-1:0] VS_BEG   = VW'(V_SYNC_BEG);
  localparam logic [VW-1:0] VS_END   = VW'(V_SYNC_END);

  localparam logic [2:0] A_BIRD_Y    = 3'd0;
  localparam logic [2:0] A_PIPE0_X   = 3'd1;
  localparam logic [2:0] A_PIPE0_GAP = 3'd2;
  localparam logic [2:0] A_PIPE1_X   = 3'd3;
  localparam logic [2:0] A_PIPE1_GAP = 3'd4;
  localparam logic [2:0] A_CONTROL   = 3'd5;
  localparam logic [2:0] A_STATUS    = 3'd6;
  localparam logic [2:0] A_IRQ_CLR   = 3'd7;

  // Raster counters
  logic [HW-1:0] hcount_q, hcount_d;
  logic [VW-1:0] vcount_q, vcount_d;

  // HPS-visible shadow copies
  logic [VW-1:0] bird_y_sh_q,    bird_y_sh_d;
  logic [HW-1:0] pipe0_x_sh_q,   pipe0_x_sh_d;
  logic [VW-1:0] pipe0_gap_sh_q, pipe0_gap_sh_d;
  logic [HW-1:0] pipe1_x_sh_q,   pipe1_x_sh_d;
  logic [VW-1:0] pipe1_gap_sh_q, pipe1_gap_sh_d;
  logic          disp_en_sh_q,   disp_en_sh_d;

  // Renderer-facing active copies
  logic [VW-1:0] bird_y_q,    bird_y_d;
  logic [HW-1:0] pipe0_x_q,   pipe0_x_d;
  logic [VW-1:0] pipe0_gap_q, pipe0_gap_d;
  logic [HW-1:0] pipe1_x_q,   pipe1_x_d;
  logic [VW-1:0] pipe1_gap_q, pipe1_gap_d;
  logic          disp_en_q,   disp_en_d;

  logic [7:0]    frame_cnt_q, frame_cnt_d;
  logic          irq_q,       irq_d;

  logic line_end_c;
  logic commit_c;
  logic wr_c;
  logic rd_c;
  logic vblank_c;
  logic unused_wdata_c;

  assign line_end_c = (hcount_q == H_LAST);
  assign commit_c   = line_end_c && (vcount_q == V_COMMIT);
  assign wr_c       = bus.chipselect & bus.write;
  assign rd_c       = bus.chipselect & bus.read;
  assign vblank_c   = (vcount_q >= V_ACT);

  // Upper write-data bits carry no register content.
  assign unused_wdata_c = &{1'b0, bus.writedata[15:11]};

  // Next-state: raster advance, shadow writes, vblank commit, irq set/clear
  always_comb begin
    hcount_d       = hcount_q + 11'd1;
    vcount_d       = vcount_q;
    bird_y_sh_d    = bird_y_sh_q;
    pipe0_x_sh_d   = pipe0_x_sh_q;
    pipe0_gap_sh_d = pipe0_gap_sh_q;
    pipe1_x_sh_d   = pipe1_x_sh_q;
    pipe1_gap_sh_d = pipe1_gap_sh_q;
    disp_en_sh_d   = disp_en_sh_q;
    bird_y_d       = bird_y_q;
    pipe0_x_d      = pipe0_x_q;
    pipe0_gap_d    = pipe0_gap_q;
    pipe1_x_d      = pipe1_x_q;
    pipe1_gap_d    = pipe1_gap_q;
    disp_en_d      = disp_en_q;
    frame_cnt_d    = frame_cnt_q;
    irq_d          = irq_q;

    if (line_end_c) begin
      hcount_d = '0;
      vcount_d = (vcount_q == V_LAST) ? '0 : vcount_q + 10'd1;
    end

    if (wr_c) begin
      case (bus.address)
        A_BIRD_Y:    bird_y_sh_d    = bus.writedata[9:0];
        A_PIPE0_X:   pipe0_x_sh_d   = bus.writedata[10:0];
        A_PIPE0_GAP: pipe0_gap_sh_d = bus.writedata[9:0];
        A_PIPE1_X:   pipe1_x_sh_d   = bus.writedata[10:0];
        A_PIPE1_GAP: pipe1_gap_sh_d = bus.writedata[9:0];
        A_CONTROL:   disp_en_sh_d   = bus.writedata[0];
        A_IRQ_CLR:   irq_d          = 1'b0;
        default:     ;
      endcase
    end

    // Commit loads pre-edge shadows; the set overrides a same-cycle clear.
    if (commit_c) begin
      bird_y_d    = bird_y_sh_q;
      pipe0_x_d   = pipe0_x_sh_q;
      pipe0_gap_d = pipe0_gap_sh_q;
      pipe1_x_d   = pipe1_x_sh_q;
      pipe1_gap_d = pipe1_gap_sh_q;
      disp_en_d   = disp_en_sh_q;
      frame_cnt_d = frame_cnt_q + 8'd1;
      irq_d       = 1'b1;
    end
  end

  // State registers
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      hcount_q       <= '0;
      vcount_q       <= '0;
      bird_y_sh_q    <= '0;
      pipe0_x_sh_q   <= '0;
      pipe0_gap_sh_q <= '0;
      pipe1_x_sh_q   <= '0;
      pipe1_gap_sh_q <= '0;
      disp_en_sh_q   <= 1'b0;
      bird_y_q       <= '0;
      pipe0_x_q      <= '0;
      pipe0_gap_q    <= '0;
      pipe1_x_q      <= '0;
      pipe1_gap_q    <= '0;
      disp_en_q      <= 1'b0;
      frame_cnt_q    <= '0;
      irq_q          <= 1'b0;
    end else begin
      hcount_q       <= hcount_d;
      vcount_q       <= vcount_d;
      bird_y_sh_q    <= bird_y_sh_d;
      pipe0_x_sh_q   <= pipe0_x_sh_d;
      pipe0_gap_sh_q <= pipe0_gap_sh_d;
      pipe1_x_sh_q   <= pipe1_x_sh_d;
      pipe1_gap_sh_q <= pipe1_gap_sh_d;
      disp_en_sh_q   <= disp_en_sh_d;
      bird_y_q       <= bird_y_d;
      pipe0_x_q      <= pipe0_x_d;
      pipe0_gap_q    <= pipe0_gap_d;
      pipe1_x_q      <= pipe1_x_d;
      pipe1_gap_q    <= pipe1_gap_d;
      disp_en_q      <= disp_en_d;
      frame_cnt_q    <= frame_cnt_d;
      irq_q          <= irq_d;
    end
  end

  // Zero-wait-state read mux; idle bus reads as zero
  always_comb begin
    bus.readdata = '0;
    if (rd_c) begin
      case (bus.address)
        A_BIRD_Y:    bus.readdata = 16'(bird_y_sh_q);
        A_PIPE0_X:   bus.readdata = 16'(pipe0_x_sh_q);
        A_PIPE0_GAP: bus.readdata = 16'(pipe0_gap_sh_q);
        A_PIPE1_X:   bus.readdata = 16'(pipe1_x_sh_q);
        A_PIPE1_GAP: bus.readdata = 16'(pipe1_gap_sh_q);
        A_CONTROL:   bus.readdata = 16'(disp_en_sh_q);
        A_STATUS:    bus.readdata = {vblank_c, 6'd0, irq_q, frame_cnt_q};
        default:     bus.readdata = '0;
      endcase
    end
  end

  // Pin and object outputs decoded from registered state
  assign hcount      = hcount_q;
  assign vcount      = vcount_q;
  assign irq         = irq_q;
  assign bird_y      = bird_y_q;
  assign pipe0_x     = pipe0_x_q;
  assign pipe0_gap   = pipe0_gap_q;
  assign pipe1_x     = pipe1_x_q;
  assign pipe1_gap   = pipe1_gap_q;
  assign VGA_CLK     = hcount_q[0];
  assign VGA_HS      = !((hcount_q >= HS_BEG) && (hcount_q <= HS_END));
  assign VGA_VS      = !((vcount_q >= VS_BEG) && (vcount_q <= VS_END));
  assign VGA_BLANK_n = disp_en_q && (hcount_q < H_ACT) && (vcount_q < V_ACT);
  assign VGA_SYNC_n  = 1'b0;

endmodule

// File: tb/tb_vga_frame_ctrl.sv
// Scoreboard bench for vga_frame_ctrl on a reduced raster geometry.
module tb_vga_frame_ctrl;

  // Reduced geometry: 16 cycles/line, 10 lines/frame, commit at pos 95
  localparam int TH = 16, THA = 10, THS0 = 12, THS1 = 13;
  localparam int TV = 10, TVA = 6,  TVS0 = 7,  TVS1 = 8;
  localparam int FRAME  = TH * TV;
  localparam int COMMIT = (TVA - 1) * TH + (TH - 1);

  localparam int P_RD = 0, P_HC = 1, P_VC = 2, P_BIRD = 3, P_P0X = 4, P_P0G = 5,
                 P_P1X = 6, P_P1G = 7, P_IRQ = 8, P_HS = 9, P_VS = 10, P_BLK = 11,
                 P_CLK = 12, P_SYNC = 13;

  typedef struct {
    int          sel;
    logic [15:0] exp;
    string       name;
  } exp_t;

  logic clk = 1'b0;
  logic reset_n = 1'b0;
  logic        irq;
  logic [10:0] hcount, pipe0_x, pipe1_x;
  logic [9:0]  vcount, bird_y, pipe0_gap, pipe1_gap;
  logic        VGA_CLK, VGA_HS, VGA_VS, VGA_BLANK_n, VGA_SYNC_n;

  vga_frame_ctrl_if bus_if ();

  vga_frame_ctrl #(
    .H_TOTAL(TH), .V_TOTAL(TV), .H_ACTIVE(THA), .H_SYNC_BEG(THS0), .H_SYNC_END(THS1),
    .V_ACTIVE(TVA), .V_SYNC_BEG(TVS0), .V_SYNC_END(TVS1)
  ) dut (
    .clk(clk), .reset_n(reset_n), .bus(bus_if), .irq(irq),
    .hcount(hcount), .vcount(vcount), .bird_y(bird_y),
    .pipe0_x(pipe0_x), .pipe0_gap(pipe0_gap), .pipe1_x(pipe1_x), .pipe1_gap(pipe1_gap),
    .VGA_CLK(VGA_CLK), .VGA_HS(VGA_HS), .VGA_VS(VGA_VS),
    .VGA_BLANK_n(VGA_BLANK_n), .VGA_SYNC_n(VGA_SYNC_n)
  );

  always #10 clk = ~clk;

  exp_t exp_q[$];
  int   probe_cnt = 0;
  int   n_vec = 0;
  int   n_err = 0;
  int   pos = 0;

  function automatic logic [15:0] probe_val(int sel);
    case (sel)
      P_RD:    return bus_if.readdata;
      P_HC:    return 16'(hcount);
      P_VC:    return 16'(vcount);
      P_BIRD:  return 16'(bird_y);
      P_P0X:   return 16'(pipe0_x);
      P_P0G:   return 16'(pipe0_gap);
      P_P1X:   return 16'(pipe1_x);
      P_P1G:   return 16'(pipe1_gap);
      P_IRQ:   return 16'(irq);
      P_HS:    return 16'(VGA_HS);
      P_VS:    return 16'(VGA_VS);
      P_BLK:   return 16'(VGA_BLANK_n);
      P_CLK:   return 16'(VGA_CLK);
      P_SYNC:  return 16'(VGA_SYNC_n);
      default: return 16'hDEAD;
    endcase
  endfunction

  // Monitor: pops and compares every observation scheduled for this cycle
  always @(negedge clk) begin
    for (int i = 0; i < probe_cnt; i++) begin
      exp_t e;
      logic [15:0] act;
      n_vec++;
      if (exp_q.size() == 0) begin
        n_err++;
        $display("FAIL scoreboard_underflow t=%0t", $time);
      end else begin
        e = exp_q.pop_front();
        act = probe_val(e.sel);
        if (act !== e.exp) begin
          n_err++;
          $display("FAIL %s t=%0t pos=%0d: got %h expected %h", e.name, $time, pos, act, e.exp);
        end
      end
    end
  end

  task automatic expect_pv(input int sel, input logic [15:0] e, input string nm);
    exp_t x;
    x.sel = sel; x.exp = e; x.name = nm;
    exp_q.push_back(x);
    probe_cnt++;
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
    if (reset_n) pos = (pos + 1) % FRAME;
    probe_cnt = 0;
    bus_if.chipselect = 1'b0;
    bus_if.read = 1'b0;
    bus_if.write = 1'b0;
    bus_if.address = 3'd0;
    bus_if.writedata = 16'd0;
  endtask

  task automatic rd(input logic [2:0] a, input logic [15:0] e, input string nm);
    bus_if.chipselect = 1'b1;
    bus_if.read = 1'b1;
    bus_if.address = a;
    expect_pv(P_RD, e, nm);
  endtask

  task automatic wr(input logic [2:0] a, input logic [15:0] d);
    bus_if.chipselect = 1'b1;
    bus_if.write = 1'b1;
    bus_if.address = a;
    bus_if.writedata = d;
  endtask

  // Expected pin levels at the current raster position
  task automatic pins(input bit en);
    int h, v;
    h = pos % TH;
    v = pos / TH;
    expect_pv(P_HC, 16'(h), "hcount");
    expect_pv(P_VC, 16'(v), "vcount");
    expect_pv(P_HS, (h >= THS0 && h <= THS1) ? 16'd0 : 16'd1, "vga_hs");
    expect_pv(P_VS, (v >= TVS0 && v <= TVS1) ? 16'd0 : 16'd1, "vga_vs");
    expect_pv(P_BLK, (en && h < THA && v < TVA) ? 16'd1 : 16'd0, "vga_blank_n");
    expect_pv(P_CLK, 16'(h % 2), "vga_clk");
    expect_pv(P_SYNC, 16'd0, "vga_sync_n");
  endtask

  task automatic run_to(input int target, input bit chk, input bit en);
    do begin
      if (chk) pins(en);
      tick();
    end while (pos != target);
  endtask

  initial begin
    #(60000 * 20);
    $display("FAIL watchdog t=%0t", $time);
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err + 1);
    $fatal(1, "watchdog");
  end

  initial begin
    bus_if.chipselect = 1'b0;
    bus_if.read = 1'b0;
    bus_if.write = 1'b0;
    bus_if.address = 3'd0;
    bus_if.writedata = 16'd0;
    tick();
    // Reset state
    pins(1'b0);
    expect_pv(P_IRQ, 16'd0, "rst_irq");
    expect_pv(P_BIRD, 16'd0, "rst_bird_y");
    expect_pv(P_P0X, 16'd0, "rst_pipe0_x");
    expect_pv(P_P0G, 16'd0, "rst_pipe0_gap");
    expect_pv(P_P1X, 16'd0, "rst_pipe1_x");
    expect_pv(P_P1G, 16'd0, "rst_pipe1_gap");
    tick();
    rd(3'd6, 16'h0000, "rst_status");
    tick();
    reset_n = 1'b1;
    pos = 0;

    // Two frames of raster with display disabled
    run_to(0, 1'b1, 1'b0);
    run_to(0, 1'b1, 1'b0);
    rd(3'd6, 16'h0102, "status_2_frames");
    expect_pv(P_IRQ, 16'd1, "irq_after_frames");
    tick();

    // bird_y shadowed until vblank entry
    run_to(2 * TH, 1'b0, 1'b0);
    wr(3'd0, 16'h0123);
    tick();
    rd(3'd0, 16'h0123, "bird_y_readback");
    expect_pv(P_BIRD, 16'd0, "bird_y_held");
    tick();
    run_to(COMMIT, 1'b0, 1'b0);
    expect_pv(P_BIRD, 16'd0, "bird_y_pre_commit");
    tick();
    expect_pv(P_BIRD, 16'h0123, "bird_y_committed");
    tick();

    // Write on the commit cycle waits one more frame
    run_to(COMMIT, 1'b0, 1'b0);
    expect_pv(P_P0X, 16'd0, "pipe0_x_at_commit");
    wr(3'd1, 16'h07FF);
    tick();
    expect_pv(P_P0X, 16'd0, "pipe0_x_not_yet");
    rd(3'd1, 16'h07FF, "pipe0_x_readback");
    tick();
    run_to(COMMIT, 1'b0, 1'b0);
    expect_pv(P_P0X, 16'd0, "pipe0_x_pre_commit2");
    tick();
    expect_pv(P_P0X, 16'h07FF, "pipe0_x_committed");
    expect_pv(P_BIRD, 16'h0123, "bird_y_kept");
    tick();

    // irq clear, and set winning over a same-cycle clear
    expect_pv(P_IRQ, 16'd1, "irq_sticky");
    wr(3'd7, 16'h0000);
    tick();
    expect_pv(P_IRQ, 16'd0, "irq_cleared");
    tick();
    run_to(COMMIT, 1'b0, 1'b0);
    expect_pv(P_IRQ, 16'd0, "irq_pre_commit");
    wr(3'd7, 16'h0001);
    tick();
    expect_pv(P_IRQ, 16'd1, "irq_set_wins");
    tick();
    run_to(COMMIT + 5, 1'b0, 1'b0);
    wr(3'd7, 16'hFFFF);
    tick();
    expect_pv(P_IRQ, 16'd0, "irq_clear_later");
    rd(3'd6, 16'h8006, "status_vblank_cnt6");
    tick();
    rd(3'd7, 16'h0000, "irq_clr_reads_zero");
    tick();
    wr(3'd6, 16'hFFFF);
    tick();
    rd(3'd6, 16'h8006, "status_write_ignored");
    tick();
    bus_if.chipselect = 1'b1;
    bus_if.address = 3'd1;
    expect_pv(P_RD, 16'h0000, "readdata_idle_zero");
    tick();

    // display_en takes effect only after the next commit
    wr(3'd5, 16'h0001);
    tick();
    rd(3'd5, 16'h0001, "control_readback");
    tick();
    run_to(COMMIT + 1, 1'b1, 1'b0);
    run_to(COMMIT + 1, 1'b1, 1'b1);

    // frame_cnt wrap (8 commits so far) and vblank status bit
    for (int f = 0; f < 247; f++) run_to(COMMIT + 1, 1'b0, 1'b0);
    run_to(COMMIT, 1'b0, 1'b0);
    rd(3'd6, 16'h01FF, "status_cnt255");
    tick();
    for (int i = 0; i < FRAME; i++) begin
      rd(3'd6, (pos / TH >= TVA) ? 16'h8100 : 16'h0100, "status_vblank_scan");
      tick();
    end

    // Asynchronous reset mid-frame discards the pending shadow write
    wr(3'd0, 16'h0055);
    tick();
    reset_n = 1'b0;
    expect_pv(P_HC, 16'd0, "async_rst_hcount");
    expect_pv(P_VC, 16'd0, "async_rst_vcount");
    expect_pv(P_BIRD, 16'd0, "async_rst_bird_y");
    expect_pv(P_P0X, 16'd0, "async_rst_pipe0_x");
    expect_pv(P_IRQ, 16'd0, "async_rst_irq");
    expect_pv(P_BLK, 16'd0, "async_rst_blank");
    tick();
    reset_n = 1'b1;
    pos = 0;
    rd(3'd0, 16'h0000, "shadow_discarded");
    pins(1'b0);
    tick();
    rd(3'd6, 16'h0000, "status_after_rst");
    pins(1'b0);
    tick();
    pins(1'b0);
    tick();
    tick();

    n_vec++;
    if (exp_q.size() != 0) begin
      n_err++;
      $display("FAIL scoreboard_leftover: got %0d entries expected 0", exp_q.size());
    end
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
